tl_ul_xbar: RTL and testbench

TL_UL_XBAR -- requirements
Module: tl_ul_xbar

---
 rtl/tl_ul_xbar.sv | 264 ++++++++++++++++++++++++++
 tb/tb_tl_ul_xbar.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_xbar.sv
// TL-UL crossbar: NUM_HOSTS hosts to NUM_DEVS devices with one outstanding request per host.
// Devices are selected by the top SEL_W address bits. Each device has its own round-robin arbiter.
// Requests to unmapped devices are answered internally with an error response.
module tl_ul_xbar #(
    parameter int unsigned NUM_HOSTS = 2,
    parameter int unsigned NUM_DEVS  = 2,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SEL_W     = 2,
    localparam int unsigned MASK_W   = DATA_W / 8,
    localparam int unsigned HIDX_W   = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    // host A channel
    input  logic [NUM_HOSTS-1:0]          h_a_valid_i,
    output logic [NUM_HOSTS-1:0]          h_a_ready_o,
    input  logic [NUM_HOSTS*3-1:0]        h_a_opcode_i,
    input  logic [NUM_HOSTS*ADDR_W-1:0]   h_a_address_i,
    input  logic [NUM_HOSTS*DATA_W-1:0]   h_a_data_i,
    input  logic [NUM_HOSTS*MASK_W-1:0]   h_a_mask_i,
    // host D channel
    output logic [NUM_HOSTS-1:0]          h_d_valid_o,
    input  logic [NUM_HOSTS-1:0]          h_d_ready_i,
    output logic [NUM_HOSTS*3-1:0]        h_d_opcode_o,
    output logic [NUM_HOSTS*DATA_W-1:0]   h_d_data_o,
    output logic [NUM_HOSTS-1:0]          h_d_error_o,
    // device A channel
    output logic [NUM_DEVS-1:0]           dv_a_valid_o,
    input  logic [NUM_DEVS-1:0]           dv_a_ready_i,
    output logic [NUM_DEVS*3-1:0]         dv_a_opcode_o,
    output logic [NUM_DEVS*ADDR_W-1:0]    dv_a_address_o,
    output logic [NUM_DEVS*DATA_W-1:0]    dv_a_data_o,
    output logic [NUM_DEVS*MASK_W-1:0]    dv_a_mask_o,
    // device D channel
    input  logic [NUM_DEVS-1:0]           dv_d_valid_i,
    output logic [NUM_DEVS-1:0]           dv_d_ready_o,
    input  logic [NUM_DEVS*3-1:0]         dv_d_opcode_i,
    input  logic [NUM_DEVS*DATA_W-1:0]    dv_d_data_i,
    input  logic [NUM_DEVS-1:0]           dv_d_error_i
);

    localparam logic [1:0] HOST_IDLE = 2'd0;
    localparam logic [1:0] HOST_WAIT = 2'd1;
    localparam logic [1:0] HOST_RESP = 2'd2;

    localparam logic [1:0] DEV_FREE  = 2'd0;
    localparam logic [1:0] DEV_ISSUE = 2'd1;
    localparam logic [1:0] DEV_BUSY  = 2'd2;

    localparam logic [2:0] OP_GET          = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK   = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_D = 3'd1;

    // host-side state and response registers
    logic [NUM_HOSTS-1:0][1:0]        hst_q, hst_d;
    logic [NUM_HOSTS-1:0][2:0]        rsp_opc_q, rsp_opc_d;
    logic [NUM_HOSTS-1:0][DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_HOSTS-1:0]             rsp_err_q, rsp_err_d;

    // device-side state, owner, arbitration pointer and forwarded request fields
    logic [NUM_DEVS-1:0][1:0]         dst_q, dst_d;
    logic [NUM_DEVS-1:0][HIDX_W-1:0]  owner_q, owner_d;
    logic [NUM_DEVS-1:0][HIDX_W-1:0]  ptr_q, ptr_d;
    logic [NUM_DEVS-1:0][2:0]         req_opc_q, req_opc_d;
    logic [NUM_DEVS-1:0][ADDR_W-1:0]  req_addr_q, req_addr_d;
    logic [NUM_DEVS-1:0][DATA_W-1:0]  req_data_q, req_data_d;
    logic [NUM_DEVS-1:0][MASK_W-1:0]  req_mask_q, req_mask_d;

    logic [NUM_HOSTS-1:0][SEL_W-1:0]    sel;
    logic [NUM_HOSTS-1:0]               mapped;
    logic [NUM_HOSTS-1:0]               granted;
    logic [NUM_DEVS-1:0][NUM_HOSTS-1:0] req;
    logic [NUM_DEVS-1:0]                gnt_any;
    logic [NUM_DEVS-1:0][HIDX_W-1:0]    gnt_idx;
    logic [NUM_DEVS-1:0]                cap;

    // Decode target device per host and build the per-device request vectors.
    always_comb begin
        sel    = '0;
        mapped = '0;
        req    = '0;
        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            sel[k]    = h_a_address_i[k*ADDR_W + ADDR_W - 1 -: SEL_W];
            mapped[k] = 32'(sel[k]) < NUM_DEVS;
        end
        for (int unsigned d = 0; d < NUM_DEVS; d++) begin
            for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
                req[d][k] = h_a_valid_i[k] && (hst_q[k] == HOST_IDLE) && mapped[k] &&
                            (32'(sel[k]) == d);
            end
        end
    end

    // Round-robin pick per FREE device: first requester at or above ptr, else lowest requester.
    always_comb begin : arb
        logic              hit_hi, hit_lo;
        logic [HIDX_W-1:0] idx_hi, idx_lo;
        gnt_any = '0;
        gnt_idx = '0;
        hit_hi  = 1'b0;
        hit_lo  = 1'b0;
        idx_hi  = '0;
        idx_lo  = '0;
        for (int unsigned d = 0; d < NUM_DEVS; d++) begin
            hit_hi = 1'b0;
            hit_lo = 1'b0;
            idx_hi = '0;
            idx_lo = '0;
            for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
                if (!hit_hi && req[d][k] && (HIDX_W'(k) >= ptr_q[d])) begin
                    hit_hi = 1'b1;
                    idx_hi = HIDX_W'(k);
                end
                if (!hit_lo && req[d][k]) begin
                    hit_lo = 1'b1;
                    idx_lo = HIDX_W'(k);
                end
            end
            gnt_any[d] = reset && (dst_q[d] == DEV_FREE) && hit_lo;
            gnt_idx[d] = hit_hi ? idx_hi : idx_lo;
        end
    end

    // Handshake and channel-valid outputs derived from FSM state and grants.
    always_comb begin
        granted      = '0;
        h_a_ready_o  = '0;
        h_d_valid_o  = '0;
        dv_a_valid_o = '0;
        dv_d_ready_o = '0;
        cap          = '0;
        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            for (int unsigned d = 0; d < NUM_DEVS; d++) begin
                if (gnt_any[d] && (gnt_idx[d] == HIDX_W'(k))) granted[k] = 1'b1;
            end
            h_a_ready_o[k] = reset && h_a_valid_i[k] && (hst_q[k] == HOST_IDLE) &&
                             (!mapped[k] || granted[k]);
            h_d_valid_o[k] = (hst_q[k] == HOST_RESP);
        end
        for (int unsigned d = 0; d < NUM_DEVS; d++) begin
            dv_a_valid_o[d] = (dst_q[d] == DEV_ISSUE);
            dv_d_ready_o[d] = (dst_q[d] == DEV_ISSUE) || (dst_q[d] == DEV_BUSY);
            cap[d]          = dv_d_valid_i[d] && dv_d_ready_o[d];
        end
    end

    // Device FSM next state: latch granted request, issue it, wait for the D response.
    always_comb begin
        dst_d      = dst_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        req_opc_d  = req_opc_q;
        req_addr_d = req_addr_q;
        req_data_d = req_data_q;
        req_mask_d = req_mask_q;
        for (int unsigned d = 0; d < NUM_DEVS; d++) begin
            case (dst_q[d])
                DEV_FREE: begin
                    if (gnt_any[d]) begin
                        dst_d[d]   = DEV_ISSUE;
                        owner_d[d] = gnt_idx[d];
                        ptr_d[d]   = (gnt_idx[d] == HIDX_W'(NUM_HOSTS - 1)) ? '0 :
                                     gnt_idx[d] + 1'b1;
                        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
                            if (gnt_idx[d] == HIDX_W'(k)) begin
                                req_opc_d[d]  = h_a_opcode_i[k*3 +: 3];
                                req_addr_d[d] = h_a_address_i[k*ADDR_W +: ADDR_W];
                                req_data_d[d] = h_a_data_i[k*DATA_W +: DATA_W];
                                req_mask_d[d] = h_a_mask_i[k*MASK_W +: MASK_W];
                            end
                        end
                    end
                end
                DEV_ISSUE: begin
                    // A response may arrive alongside the A handshake; it completes the access.
                    if (cap[d]) dst_d[d] = DEV_FREE;
                    else if (dv_a_ready_i[d]) dst_d[d] = DEV_BUSY;
                end
                DEV_BUSY: begin
                    if (cap[d]) dst_d[d] = DEV_FREE;
                end
                default: dst_d[d] = DEV_FREE;
            endcase
        end
    end

    // Host FSM next state: accept, wait for the owning device (or answer unmapped), hold response.
    always_comb begin
        hst_d      = hst_q;
        rsp_opc_d  = rsp_opc_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        for (int unsigned k = 0; k < NUM_HOSTS; k++) begin
            case (hst_q[k])
                HOST_IDLE: begin
                    if (h_a_ready_o[k]) begin
                        if (mapped[k]) begin
                            hst_d[k] = HOST_WAIT;
                        end else begin
                            hst_d[k]      = HOST_RESP;
                            rsp_data_d[k] = '0;
                            rsp_err_d[k]  = 1'b1;
                            rsp_opc_d[k]  = (h_a_opcode_i[k*3 +: 3] == OP_GET) ?
                                            OP_ACCESS_ACK_D : OP_ACCESS_ACK;
                        end
                    end
                end
                HOST_WAIT: begin
                    for (int unsigned d = 0; d < NUM_DEVS; d++) begin
                        if (cap[d] && (owner_q[d] == HIDX_W'(k))) begin
                            hst_d[k]      = HOST_RESP;
                            rsp_opc_d[k]  = dv_d_opcode_i[d*3 +: 3];
                            rsp_data_d[k] = dv_d_data_i[d*DATA_W +: DATA_W];
                            rsp_err_d[k]  = dv_d_error_i[d];
                        end
                    end
                end
                HOST_RESP: begin
                    if (h_d_ready_i[k]) hst_d[k] = HOST_IDLE;
                end
                default: hst_d[k] = HOST_IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset; reset abandons in-flight accesses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hst_q      <= '0;
            rsp_opc_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
            dst_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            req_opc_q  <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_mask_q <= '0;
        end else begin
            hst_q      <= hst_d;
            rsp_opc_q  <= rsp_opc_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            dst_q      <= dst_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            req_opc_q  <= req_opc_d;
            req_addr_q <= req_addr_d;
            req_data_q <= req_data_d;
            req_mask_q <= req_mask_d;
        end
    end

    assign h_d_opcode_o   = rsp_opc_q;
    assign h_d_data_o     = rsp_data_q;
    assign h_d_error_o    = rsp_err_q;
    assign dv_a_opcode_o  = req_opc_q;
    assign dv_a_address_o = req_addr_q;
    assign dv_a_data_o    = req_data_q;
    assign dv_a_mask_o    = req_mask_q;

endmodule

// File: tb/tb_tl_ul_xbar.sv
// Directed bench for tl_ul_xbar (2 hosts, 2 devices, 12-bit address, 32-bit data).
// Devices are modelled as always-ready responders with fixed D fields unless a test changes them.
module tb_tl_ul_xbar;

    localparam int NH = 2;
    localparam int ND = 2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic             clk;
    logic             reset;
    logic [NH-1:0]    h_a_valid_i;
    logic [NH-1:0]    h_a_ready_o;
    logic [NH*3-1:0]  h_a_opcode_i;
    logic [NH*AW-1:0] h_a_address_i;
    logic [NH*DW-1:0] h_a_data_i;
    logic [NH*MW-1:0] h_a_mask_i;
    logic [NH-1:0]    h_d_valid_o;
    logic [NH-1:0]    h_d_ready_i;
    logic [NH*3-1:0]  h_d_opcode_o;
    logic [NH*DW-1:0] h_d_data_o;
    logic [NH-1:0]    h_d_error_o;
    logic [ND-1:0]    dv_a_valid_o;
    logic [ND-1:0]    dv_a_ready_i;
    logic [ND*3-1:0]  dv_a_opcode_o;
    logic [ND*AW-1:0] dv_a_address_o;
    logic [ND*DW-1:0] dv_a_data_o;
    logic [ND*MW-1:0] dv_a_mask_o;
    logic [ND-1:0]    dv_d_valid_i;
    logic [ND-1:0]    dv_d_ready_o;
    logic [ND*3-1:0]  dv_d_opcode_i;
    logic [ND*DW-1:0] dv_d_data_i;
    logic [ND-1:0]    dv_d_error_i;

    int n_checks = 0;
    int n_errors = 0;

    tl_ul_xbar #(
        .NUM_HOSTS (NH),
        .NUM_DEVS  (ND),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SEL_W     (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .h_a_valid_i    (h_a_valid_i),
        .h_a_ready_o    (h_a_ready_o),
        .h_a_opcode_i   (h_a_opcode_i),
        .h_a_address_i  (h_a_address_i),
        .h_a_data_i     (h_a_data_i),
        .h_a_mask_i     (h_a_mask_i),
        .h_d_valid_o    (h_d_valid_o),
        .h_d_ready_i    (h_d_ready_i),
        .h_d_opcode_o   (h_d_opcode_o),
        .h_d_data_o     (h_d_data_o),
        .h_d_error_o    (h_d_error_o),
        .dv_a_valid_o   (dv_a_valid_o),
        .dv_a_ready_i   (dv_a_ready_i),
        .dv_a_opcode_o  (dv_a_opcode_o),
        .dv_a_address_o (dv_a_address_o),
        .dv_a_data_o    (dv_a_data_o),
        .dv_a_mask_o    (dv_a_mask_o),
        .dv_d_valid_i   (dv_d_valid_i),
        .dv_d_ready_o   (dv_d_ready_o),
        .dv_d_opcode_i  (dv_d_opcode_i),
        .dv_d_data_i    (dv_d_data_i),
        .dv_d_error_i   (dv_d_error_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_req(input int k, input logic [2:0] op, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
        h_a_valid_i[k]             = 1'b1;
        h_a_opcode_i[k*3 +: 3]     = op;
        h_a_address_i[k*AW +: AW]  = addr;
        h_a_data_i[k*DW +: DW]     = data;
        h_a_mask_i[k*MW +: MW]     = '1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        h_a_valid_i   = '0;
        h_a_opcode_i  = '0;
        h_a_address_i = '0;
        h_a_data_i    = '0;
        h_a_mask_i    = '0;
        h_d_ready_i   = 2'b11;
        dv_a_ready_i  = 2'b11;
        dv_d_valid_i  = 2'b11;
        dv_d_opcode_i = {3'd1, 3'd0};
        dv_d_data_i   = {32'hDEADBEEF, 32'h12345678};
        dv_d_error_i  = 2'b00;

        // Reset state, with a request pending to show ready stays low in reset.
        host_req(0, 3'd4, 12'h010, 32'h0);
        tick();
        tick();
        check_eq("rst_a_ready", 64'(h_a_ready_o), 64'h0);
        check_eq("rst_d_valid", 64'(h_d_valid_o), 64'h0);
        check_eq("rst_dv_a_valid", 64'(dv_a_valid_o), 64'h0);
        check_eq("rst_dv_d_ready", 64'(dv_d_ready_o), 64'h0);
        check_eq("rst_d_data", h_d_data_o, 64'h0);
        h_a_valid_i = '0;
        reset = 1'b1;
        tick();

        // Host0 Get to dev1, device answers immediately.
        host_req(0, 3'd4, 12'h404, 32'h0);
        #1;
        check_eq("get_a_ready_t", 64'(h_a_ready_o), 64'h1);
        tick();
        h_a_valid_i = '0;
        check_eq("get_dv_a_valid_t1", 64'(dv_a_valid_o), 64'h2);
        check_eq("get_dv_addr", 64'(dv_a_address_o[23:12]), 64'h404);
        check_eq("get_dv_opcode", 64'(dv_a_opcode_o[5:3]), 64'h4);
        check_eq("get_d_valid_t1", 64'(h_d_valid_o), 64'h0);
        tick();
        check_eq("get_d_valid_t2", 64'(h_d_valid_o), 64'h1);
        check_eq("get_d_data", 64'(h_d_data_o[31:0]), 64'hDEADBEEF);
        check_eq("get_d_opcode", 64'(h_d_opcode_o[2:0]), 64'h1);
        check_eq("get_d_error", 64'(h_d_error_o[0]), 64'h0);
        check_eq("get_dv_idle_t2", 64'(dv_a_valid_o), 64'h0);
        tick();
        check_eq("get_d_done", 64'(h_d_valid_o), 64'h0);

        // Unmapped Get from host1 and unmapped PutFullData from host0.
        host_req(1, 3'd4, 12'hC00, 32'h0);
        #1;
        check_eq("unm_a_ready", 64'(h_a_ready_o), 64'h2);
        tick();
        h_a_valid_i = '0;
        check_eq("unm_no_dev", 64'(dv_a_valid_o), 64'h0);
        check_eq("unm_d_valid_t1", 64'(h_d_valid_o), 64'h2);
        check_eq("unm_error", 64'(h_d_error_o[1]), 64'h1);
        check_eq("unm_data", 64'(h_d_data_o[63:32]), 64'h0);
        check_eq("unm_opcode_get", 64'(h_d_opcode_o[5:3]), 64'h1);
        tick();
        host_req(0, 3'd0, 12'hC00, 32'hAAAA5555);
        #1;
        tick();
        h_a_valid_i = '0;
        check_eq("unm_put_valid", 64'(h_d_valid_o), 64'h1);
        check_eq("unm_opcode_put", 64'(h_d_opcode_o[2:0]), 64'h0);
        check_eq("unm_put_error", 64'(h_d_error_o[0]), 64'h1);
        check_eq("unm_put_data", 64'(h_d_data_o[31:0]), 64'h0);
        tick();

        // Host0 -> dev0 and host1 -> dev1 in parallel.
        host_req(0, 3'd0, 12'h010, 32'h11111111);
        host_req(1, 3'd4, 12'h404, 32'h0);
        #1;
        check_eq("par_a_ready", 64'(h_a_ready_o), 64'h3);
        tick();
        h_a_valid_i = '0;
        check_eq("par_dv_a_valid", 64'(dv_a_valid_o), 64'h3);
        check_eq("par_dv0_data", 64'(dv_a_data_o[31:0]), 64'h11111111);
        check_eq("par_dv0_mask", 64'(dv_a_mask_o[3:0]), 64'hF);
        tick();
        check_eq("par_d_valid", 64'(h_d_valid_o), 64'h3);
        check_eq("par_d1_data", 64'(h_d_data_o[63:32]), 64'hDEADBEEF);
        check_eq("par_d0_opcode", 64'(h_d_opcode_o[2:0]), 64'h0);
        check_eq("par_d1_opcode", 64'(h_d_opcode_o[5:3]), 64'h1);
        tick();

        // Round-robin on dev0 from a fresh reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        host_req(0, 3'd0, 12'h010, 32'h1);
        host_req(1, 3'd0, 12'h020, 32'h2);
        #1;
        check_eq("rr_first_host0", 64'(h_a_ready_o), 64'h1);
        tick();
        h_a_valid_i = '0;
        check_eq("rr_first_addr", 64'(dv_a_address_o[11:0]), 64'h010);
        tick();
        check_eq("rr_first_resp", 64'(h_d_valid_o), 64'h1);
        tick();
        host_req(0, 3'd0, 12'h030, 32'h3);
        host_req(1, 3'd0, 12'h020, 32'h2);
        #1;
        check_eq("rr_second_host1", 64'(h_a_ready_o), 64'h2);
        tick();
        h_a_valid_i[1] = 1'b0;
        #1;
        check_eq("rr_dev_busy_block", 64'(h_a_ready_o), 64'h0);
        check_eq("rr_second_addr", 64'(dv_a_address_o[11:0]), 64'h020);
        tick();
        check_eq("rr_host0_after_free", 64'(h_a_ready_o), 64'h1);
        tick();
        h_a_valid_i = '0;
        check_eq("rr_third_addr", 64'(dv_a_address_o[11:0]), 64'h030);
        check_eq("rr_third_data", 64'(dv_a_data_o[31:0]), 64'h3);
        tick();
        tick();

        // Host0 holds off the response for 5 cycles while attempting a new request.
        h_d_ready_i = 2'b10;
        host_req(0, 3'd4, 12'h404, 32'h0);
        #1;
        tick();
        h_a_valid_i = '0;
        tick();
        check_eq("hold_d_valid", 64'(h_d_valid_o[0]), 64'h1);
        host_req(0, 3'd4, 12'h010, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("hold_a_ready", 64'(h_a_ready_o[0]), 64'h0);
            check_eq("hold_valid", 64'(h_d_valid_o[0]), 64'h1);
            check_eq("hold_data", 64'(h_d_data_o[31:0]), 64'hDEADBEEF);
            tick();
        end
        h_a_valid_i = '0;
        h_d_ready_i = 2'b11;
        tick();
        check_eq("hold_release", 64'(h_d_valid_o[0]), 64'h0);

        // Reset while dev0 is BUSY; a late device response must be dropped.
        dv_d_valid_i = 2'b00;
        host_req(0, 3'd0, 12'h010, 32'h5);
        #1;
        tick();
        h_a_valid_i = '0;
        check_eq("busy_issue", 64'(dv_a_valid_o[0]), 64'h1);
        tick();
        check_eq("busy_a_done", 64'(dv_a_valid_o[0]), 64'h0);
        check_eq("busy_d_ready", 64'(dv_d_ready_o[0]), 64'h1);
        reset = 1'b0;
        tick();
        check_eq("mid_rst_a_ready", 64'(h_a_ready_o), 64'h0);
        check_eq("mid_rst_d_valid", 64'(h_d_valid_o), 64'h0);
        check_eq("mid_rst_dv_a_valid", 64'(dv_a_valid_o), 64'h0);
        check_eq("mid_rst_dv_d_ready", 64'(dv_d_ready_o), 64'h0);
        check_eq("mid_rst_d_data", h_d_data_o, 64'h0);
        check_eq("mid_rst_d_opcode", 64'(h_d_opcode_o), 64'h0);
        check_eq("mid_rst_d_error", 64'(h_d_error_o), 64'h0);
        check_eq("mid_rst_dv_addr", 64'(dv_a_address_o), 64'h0);
        check_eq("mid_rst_dv_data", dv_a_data_o, 64'h0);
        reset = 1'b1;
        dv_d_valid_i = 2'b11;
        tick();
        tick();
        check_eq("late_rsp_dropped", 64'(h_d_valid_o), 64'h0);
        check_eq("late_rsp_no_ready", 64'(dv_d_ready_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
